den_gen_seq: RTL

- Sequential scheduler for pack denominator generation.
- Time-multiplexes one shared multi-cycle reciprocal unit across N cell SOC values.
- Accumulates either sum(SOC) (mode 0) or sum(1/SOC) (mode 1) into a 32-bit denominator.
- Sits between the SOC register bank and the balancing-weight divider; replaces N parallel reciprocal instances with one.

---
 rtl/den_pkg.sv | 16 +
 rtl/den_gen_seq_sat_acc32.sv | 33 +++
 rtl/den_gen_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/den_pkg.sv
// Shared types and constants for the pack denominator generator.
package den_pkg;

    localparam int          SOC_W      = 32;
    localparam logic [31:0] DEN_SAT    = 32'hFFFF_FFFF;
    localparam logic [31:0] ZERO_RECIP = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        st_idle,
        st_sum,
        st_issue,
        st_wait,
        st_done
    } state_t;

endpackage

// File: rtl/den_gen_seq_sat_acc32.sv
// Saturating 32-bit accumulator with synchronous clear, add enable and a sticky overflow flag.
module sat_acc32
    import den_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add_en,
    input  logic [SOC_W-1:0] addend,
    output logic [SOC_W-1:0] acc,
    output logic             ovf
);

    logic [SOC_W:0] sum;

    assign sum = {1'b0, acc} + {1'b0, addend};

    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (add_en) begin
            if (sum[SOC_W]) begin
                acc <= DEN_SAT;
                ovf <= 1'b1;
            end else begin
                acc <= sum[SOC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/den_gen_seq.sv
// Sequential pack denominator generator sharing one reciprocal unit across N cells.
// Optional reciprocal timeout enabled by defining DEN_GEN_SEQ_TIMEOUT_EN.
module den_gen_seq
    import den_pkg::*;
#(
    parameter int N       = 3,
    parameter int IDX_W   = (N > 1) ? $clog2(N) : 1,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [N*32-1:0]  soc_flat,
    output logic             recip_req,
    output logic [31:0]      recip_operand,
    input  logic             recip_valid,
    input  logic [31:0]      recip_result,
    output logic [31:0]      den,
    output logic             done,
    output logic             busy,
    output logic             err_zero,
    output logic             err_ovf,
    output logic             err_timeout
);

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx;
    logic [SOC_W-1:0] soc_q [N];
    logic [SOC_W-1:0] cur_soc;
    logic [SOC_W-1:0] den_q;
    logic [SOC_W-1:0] den_val;
    logic             last;
    logic             accept;
    logic             err_zero_q;

    logic             acc_clr;
    logic             acc_add;
    logic [SOC_W-1:0] acc_addend;
    logic [SOC_W-1:0] acc;
    logic             acc_ovf;
    logic             idx_inc;
    logic             zero_hit;
    logic             to_hit;

    assign cur_soc = soc_q[idx];
    assign last    = (idx == IDX_W'(N - 1));
    assign accept  = (state == st_idle) && start;

    sat_acc32 u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr),
        .add_en (acc_add),
        .addend (acc_addend),
        .acc    (acc),
        .ovf    (acc_ovf)
    );

`ifdef DEN_GEN_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt;
    logic            err_to_q;

    assign to_hit = (state == st_wait) && !recip_valid && (to_cnt == TO_W'(TIMEOUT - 1));

    // Counter is zero whenever outside WAIT, so each WAIT entry starts a fresh window.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt   <= '0;
            err_to_q <= 1'b0;
        end else begin
            if (state != st_wait) to_cnt <= '0;
            else                  to_cnt <= to_cnt + 1'b1;
            if (accept)      err_to_q <= 1'b0;
            else if (to_hit) err_to_q <= 1'b1;
        end
    end

    assign err_timeout = err_to_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT > 0);
    assign to_hit         = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    // A timed-out run reports a saturated denominator rather than a partial sum.
    assign den_val = err_timeout ? DEN_SAT : acc;

    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    always_comb begin
        state_nx   = state;
        acc_clr    = 1'b0;
        acc_add    = 1'b0;
        acc_addend = cur_soc;
        idx_inc    = 1'b0;
        zero_hit   = 1'b0;
        recip_req  = 1'b0;
        case (state)
            st_idle: begin
                if (start) begin
                    acc_clr  = 1'b1;
                    state_nx = mode ? st_issue : st_sum;
                end
            end
            st_sum: begin
                acc_add = 1'b1;
                if (last) state_nx = st_done;
                else      idx_inc  = 1'b1;
            end
            st_issue: begin
                if (cur_soc != '0) begin
                    recip_req = 1'b1;
                    state_nx  = st_wait;
                end else begin
                    zero_hit   = 1'b1;
                    acc_add    = 1'b1;
                    acc_addend = ZERO_RECIP;
                    if (last) state_nx = st_done;
                    else      idx_inc  = 1'b1;
                end
            end
            st_wait: begin
                if (recip_valid) begin
                    acc_add    = 1'b1;
                    acc_addend = recip_result;
                    if (last) begin
                        state_nx = st_done;
                    end else begin
                        idx_inc  = 1'b1;
                        state_nx = st_issue;
                    end
                end else if (to_hit) begin
                    state_nx = st_done;
                end
            end
            st_done:  state_nx = st_idle;
            default:  state_nx = st_idle;
        endcase
    end

    // NOTE: the SOC snapshot is reset too, so a post-reset run never sees stale operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= st_idle;
            idx        <= '0;
            err_zero_q <= 1'b0;
            den_q      <= '0;
            for (int i = 0; i < N; i++) soc_q[i] <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                idx        <= '0;
                err_zero_q <= 1'b0;
                for (int i = 0; i < N; i++) soc_q[i] <= soc_flat[SOC_W*i +: SOC_W];
            end else begin
                if (idx_inc)  idx        <= idx + 1'b1;
                if (zero_hit) err_zero_q <= 1'b1;
            end
            if (state == st_done) den_q <= den_val;
        end
    end

    assign recip_operand = ((state == st_issue) || (state == st_wait)) ? cur_soc : '0;
    assign den           = (state == st_done) ? den_val : den_q;
    assign done          = (state == st_done);
    assign busy          = (state != st_idle);
    assign err_zero      = err_zero_q;
    assign err_ovf       = acc_ovf;

endmodule
